// File: rtl/demod_pkg.sv
// Shared types and defaults for the I/Q sample sequencer.
// The state enumeration, default widths/limits and a small helper used by the
// skew monitor live here.
package demod_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_COUNT_WIDTH = 20;
    localparam int DEF_SKEW_LIMIT  = 16;

    // True when exactly one of the two FIFOs is empty (one stream ahead).
    function automatic logic is_one_sided(input logic a_empty, input logic b_empty);
        return a_empty ^ b_empty;
    endfunction

endpackage

// File: rtl/iq_sample_sequencer_if.sv
// Valid/ready handshake carrying a paired I/Q sample to the demod core.
// master = sequencer side (drives the pair), slave = demod side (drives ready).
interface iq_sample_sequencer_if #(
    parameter int DATA_WIDTH = demod_pkg::DEF_DATA_WIDTH
);
    logic                  dm_valid;
    logic [DATA_WIDTH-1:0] dm_i;
    logic [DATA_WIDTH-1:0] dm_q;
    logic                  dm_ready;

    modport master (
        output dm_valid,
        output dm_i,
        output dm_q,
        input  dm_ready
    );

    modport slave (
        input  dm_valid,
        input  dm_i,
        input  dm_q,
        output dm_ready
    );
endinterface

// File: rtl/iq_sample_sequencer_skew.sv
// iq_skew_monitor: counts consecutive RUN cycles in which exactly one of the
// I/Q FIFOs holds data, and raises a sticky skew flag once that run length
// reaches SKEW_LIMIT. Cleared by an accepted start or by reset.
module iq_skew_monitor
    import demod_pkg::*;
#(
    parameter int SKEW_LIMIT = DEF_SKEW_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic i_empty,
    input  logic q_empty,
    output logic skew_err
);
    localparam int CNT_W = $clog2(SKEW_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SKEW_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKEW_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] run_cnt_r;
    logic             skew_err_r;

    assign skew_err = skew_err_r;

    // One-sided-empty run counter (saturating) and sticky flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_cnt_r  <= {CNT_W{1'b0}};
            skew_err_r <= 1'b0;
        end else if (clear) begin
            run_cnt_r  <= {CNT_W{1'b0}};
            skew_err_r <= 1'b0;
        end else if (!active) begin
            run_cnt_r  <= {CNT_W{1'b0}};
        end else if (is_one_sided(i_empty, q_empty)) begin
            if (run_cnt_r != CNT_MAX) begin
                run_cnt_r <= run_cnt_r + CNT_ONE;
            end
            if (run_cnt_r == CNT_LAST) begin
                skew_err_r <= 1'b1;
            end
        end else begin
            run_cnt_r <= {CNT_W{1'b0}};
        end
    end
endmodule

// File: rtl/iq_sample_sequencer.sv
// iq_sample_sequencer: pops the I and Q FWFT FIFOs in lockstep, presents the
// pairs to the demod over a valid/ready handshake, counts a programmed frame
// and reports done.
// Optional build macro IQ_SKEW_CHECK_EN adds the one-sided-empty skew monitor;
// without it skew_err is constant 0.
module iq_sample_sequencer
    import demod_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int SKEW_LIMIT  = DEF_SKEW_LIMIT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_samples,
    input  logic                   i_empty,
    input  logic [DATA_WIDTH-1:0]  i_dout,
    output logic                   i_rd_en,
    input  logic                   q_empty,
    input  logic [DATA_WIDTH-1:0]  q_dout,
    output logic                   q_rd_en,
    iq_sample_sequencer_if.master  dm,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] sample_count,
    output logic                   skew_err
);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

    seq_state_t             state_r;
    logic [COUNT_WIDTH-1:0] frame_len_r;
    logic [COUNT_WIDTH-1:0] issued_r;
    logic [COUNT_WIDTH-1:0] sample_count_r;
    logic                   dm_valid_r;
    logic [DATA_WIDTH-1:0]  dm_i_r;
    logic [DATA_WIDTH-1:0]  dm_q_r;
    logic                   busy_r;
    logic                   done_r;

    logic                   accept_s;
    logic                   pop_s;
    logic [COUNT_WIDTH-1:0] issued_next_s;

    assign accept_s      = dm_valid_r && dm.dm_ready;
    assign issued_next_s = issued_r + CNT_ONE;

    // A pop needs both heads present, frame budget left, and the output
    // register free or being emptied this very cycle (no bubble).
    assign pop_s = (state_r == RUN) && !i_empty && !q_empty &&
                   (issued_r < frame_len_r) && (!dm_valid_r || dm.dm_ready);

    assign i_rd_en      = pop_s;
    assign q_rd_en      = pop_s;
    assign dm.dm_valid  = dm_valid_r;
    assign dm.dm_i      = dm_i_r;
    assign dm.dm_q      = dm_q_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign sample_count = sample_count_r;

    // Frame sequencer: state, output pair register, counters and status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            frame_len_r    <= CNT_ZERO;
            issued_r       <= CNT_ZERO;
            sample_count_r <= CNT_ZERO;
            dm_valid_r     <= 1'b0;
            dm_i_r         <= {DATA_WIDTH{1'b0}};
            dm_q_r         <= {DATA_WIDTH{1'b0}};
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            if (accept_s) begin
                sample_count_r <= sample_count_r + CNT_ONE;
            end
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        frame_len_r    <= num_samples;
                        issued_r       <= CNT_ZERO;
                        sample_count_r <= CNT_ZERO;
                        if (num_samples == CNT_ZERO) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (pop_s) begin
                        dm_i_r     <= i_dout;
                        dm_q_r     <= q_dout;
                        dm_valid_r <= 1'b1;
                        issued_r   <= issued_next_s;
                        if (issued_next_s == frame_len_r) begin
                            state_r <= DRAIN;
                        end
                    end else if (accept_s) begin
                        dm_valid_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The last pair is always pending here; its handshake ends the frame.
                    if (accept_s) begin
                        dm_valid_r <= 1'b0;
                        state_r    <= DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    dm_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

`ifdef IQ_SKEW_CHECK_EN
    logic start_ok_s;
    assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));

    iq_skew_monitor #(
        .SKEW_LIMIT (SKEW_LIMIT)
    ) u_skew_monitor (
        .clock    (clock),
        .reset    (reset),
        .clear    (start_ok_s),
        .active   (state_r == RUN),
        .i_empty  (i_empty),
        .q_empty  (q_empty),
        .skew_err (skew_err)
    );
`else
    // SKEW_LIMIT is never negative, so this is a constant 0.
    assign skew_err = (SKEW_LIMIT < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_iq_sample_sequencer.sv
// Self-checking bench for iq_sample_sequencer. The I/Q FIFOs are modelled as
// queues; every pair leaving the DUT is checked against the stream of words
// pushed into the FIFOs, in order.
module tb_iq_sample_sequencer;
    localparam int DW = 32;
    localparam int CW = 20;
    localparam int SL = 16;
`ifdef IQ_SKEW_CHECK_EN
    localparam logic EXP_SKEW = 1'b1;
`else
    localparam logic EXP_SKEW = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_samples = '0;
    logic          i_empty = 1'b1;
    logic          q_empty = 1'b1;
    logic [DW-1:0] i_dout = '0;
    logic [DW-1:0] q_dout = '0;
    logic          i_rd_en, q_rd_en, busy, done, skew_err;
    logic [CW-1:0] sample_count;

    iq_sample_sequencer_if #(.DATA_WIDTH(DW)) dm();

    iq_sample_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .SKEW_LIMIT(SL)) dut (
        .clock(clock), .reset(reset), .start(start), .num_samples(num_samples),
        .i_empty(i_empty), .i_dout(i_dout), .i_rd_en(i_rd_en),
        .q_empty(q_empty), .q_dout(q_dout), .q_rd_en(q_rd_en),
        .dm(dm), .busy(busy), .done(done), .sample_count(sample_count),
        .skew_err(skew_err)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] ifq[$], qfq[$], exp_i[$], exp_q[$];
    int   pend_i = 0, pend_q = 0, ready_mode = 0;
    logic ready_val = 1'b1;
    int   step_no = 0, acc_cnt = 0, pop_cnt = 0, first_acc_step = -1, last_acc_step = -1;
    logic smp_done, smp_busy, smp_skew, smp_acc;
    logic [CW-1:0] smp_count;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_i, prev_q;

    task automatic upd_fifo();
        i_empty = (ifq.size() == 0);
        q_empty = (qfq.size() == 0);
        i_dout  = i_empty ? '0 : ifq[0];
        q_dout  = q_empty ? '0 : qfq[0];
    endtask

    task automatic push_i(input logic [DW-1:0] v);
        ifq.push_back(v); exp_i.push_back(v);
    endtask

    task automatic push_q(input logic [DW-1:0] v);
        qfq.push_back(v); exp_q.push_back(v);
    endtask

    task automatic flush_all();
        ifq.delete(); qfq.delete(); exp_i.delete(); exp_q.delete();
        pend_i = 0; pend_q = 0;
        upd_fifo();
    endtask

    // One clock: sample/check at negedge, then apply FIFO pops, feed and ready after posedge.
    task automatic step();
        logic pi, pq;
        logic [DW-1:0] ei, eq;
        @(negedge clock);
        pi = i_rd_en; pq = q_rd_en;
        smp_acc = dm.dm_valid && dm.dm_ready;
        smp_done = done; smp_busy = busy; smp_count = sample_count; smp_skew = skew_err;
        vectors++;
        if (pi !== pq) begin
            miscompares++; $display("FAIL rd_en_lockstep: i_rd_en=%b q_rd_en=%b required equal", pi, pq);
        end
        if (dm.dm_valid && !dm.dm_ready) begin
            vectors++;
            if (pi) begin
                miscompares++; $display("FAIL pop_while_stalled: i_rd_en=%b required 0", pi);
            end
        end
        if (prev_stall) begin
            vectors++;
            if (dm.dm_valid !== 1'b1 || dm.dm_i !== prev_i || dm.dm_q !== prev_q) begin
                miscompares++;
                $display("FAIL hold_stable: valid=%b i=%h q=%h required 1 %h %h",
                         dm.dm_valid, dm.dm_i, dm.dm_q, prev_i, prev_q);
            end
        end
        prev_stall = dm.dm_valid && !dm.dm_ready;
        prev_i = dm.dm_i; prev_q = dm.dm_q;
        if (smp_acc) begin
            acc_cnt++;
            if (first_acc_step < 0) first_acc_step = step_no;
            last_acc_step = step_no;
            vectors++;
            if (exp_i.size() == 0 || exp_q.size() == 0) begin
                miscompares++; $display("FAIL pair_extra: got i=%h q=%h, required no pair", dm.dm_i, dm.dm_q);
            end else begin
                ei = exp_i.pop_front(); eq = exp_q.pop_front();
                if (dm.dm_i !== ei || dm.dm_q !== eq) begin
                    miscompares++;
                    $display("FAIL pair_order: got i=%h q=%h required i=%h q=%h", dm.dm_i, dm.dm_q, ei, eq);
                end
            end
        end
        @(posedge clock); #1;
        step_no++;
        if (pi) begin
            pop_cnt++;
            vectors++;
            if (ifq.size() == 0 || qfq.size() == 0) begin
                miscompares++; $display("FAIL pop_empty: i_size=%0d q_size=%0d required nonzero", ifq.size(), qfq.size());
            end else begin
                void'(ifq.pop_front()); void'(qfq.pop_front());
            end
        end
        if (pend_i > 0 && $urandom_range(0, 1) == 1) begin push_i($urandom); pend_i--; end
        if (pend_q > 0 && $urandom_range(0, 1) == 1) begin push_q($urandom); pend_q--; end
        case (ready_mode)
            0: dm.dm_ready = ready_val;
            1: dm.dm_ready = ((step_no % 4) == 0) || ((step_no % 4) == 3);
            2: dm.dm_ready = ($urandom_range(0, 1) == 1);
            default: dm.dm_ready = 1'b1;
        endcase
        upd_fifo();
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1; num_samples = CW'(n);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        do begin step(); k++; end while (!smp_done && k < budget);
        vectors++;
        if (!smp_done) begin
            miscompares++; $display("FAIL %s_timeout: done=%b after %0d cycles required 1", name, smp_done, k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        dm.dm_ready = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({dm.dm_valid, busy, done, i_rd_en, q_rd_en, skew_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: valid/busy/done/ird/qrd/skew=%b required 000000",
                     {dm.dm_valid, busy, done, i_rd_en, q_rd_en, skew_err});
        end
        vectors++;
        if (dm.dm_i !== '0 || dm.dm_q !== '0) begin
            miscompares++; $display("FAIL reset_data: i=%h q=%h required 0 0", dm.dm_i, dm.dm_q);
        end
        vectors++;
        if (sample_count !== '0) begin
            miscompares++; $display("FAIL reset_count: got %0d required 0", sample_count);
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_full_throughput();
        ready_mode = 0; ready_val = 1'b1; dm.dm_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push_i(DW'(32'h100 + k)); push_q(DW'(32'h200 + k));
        end
        upd_fifo();
        acc_cnt = 0; pop_cnt = 0; first_acc_step = -1;
        pulse_start(8);
        wait_done(60, "full");
        vectors++;
        if (acc_cnt != 8) begin miscompares++; $display("FAIL full_pairs: got %0d required 8", acc_cnt); end
        vectors++;
        if (last_acc_step - first_acc_step != 7) begin
            miscompares++; $display("FAIL full_consecutive: span %0d required 7", last_acc_step - first_acc_step);
        end
        vectors++;
        if (step_no - 1 != last_acc_step + 1) begin
            miscompares++; $display("FAIL full_done_latency: done at %0d required %0d", step_no - 1, last_acc_step + 1);
        end
        vectors++;
        if (smp_count !== CW'(8) || smp_busy !== 1'b0) begin
            miscompares++; $display("FAIL full_count: count=%0d busy=%b required 8 0", smp_count, smp_busy);
        end
    endtask

    task automatic run_frame(input int n, input int mode, input string name);
        int a0, p0;
        ready_mode = mode;
        for (int k = 0; k < n; k++) begin push_i($urandom); push_q($urandom); end
        upd_fifo();
        a0 = acc_cnt; p0 = pop_cnt;
        pulse_start(n);
        wait_done(300, name);
        vectors++;
        if (acc_cnt - a0 != n || pop_cnt - p0 != n || smp_count !== CW'(n)) begin
            miscompares++;
            $display("FAIL %s_counts: pairs=%0d pops=%0d count=%0d required %0d", name, acc_cnt - a0, pop_cnt - p0, smp_count, n);
        end
        vectors++;
        if (exp_i.size() != 0 || ifq.size() != 0) begin
            miscompares++; $display("FAIL %s_leftover: exp=%0d fifo=%0d required 0 0", name, exp_i.size(), ifq.size());
        end
    endtask

    task automatic test_backpressure();
        run_frame(12, 1, "bp_pattern");
        run_frame(10, 2, "bp_random");
    endtask

    task automatic test_skewed_arrival();
        int p0, a0;
        ready_mode = 0; ready_val = 1'b1;
        for (int k = 0; k < 6; k++) push_i($urandom);
        upd_fifo();
        a0 = acc_cnt;
        pulse_start(6);
        p0 = pop_cnt;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 10) begin
                vectors++;
                if (smp_skew !== 1'b0) begin miscompares++; $display("FAIL skew_early: got %b required 0", smp_skew); end
            end
        end
        vectors++;
        if (pop_cnt != p0) begin miscompares++; $display("FAIL skew_pops: got %0d required 0", pop_cnt - p0); end
        vectors++;
        if (smp_skew !== EXP_SKEW) begin miscompares++; $display("FAIL skew_flag: got %b required %b", smp_skew, EXP_SKEW); end
        for (int k = 0; k < 6; k++) push_q($urandom);
        upd_fifo();
        wait_done(60, "skew");
        vectors++;
        if (acc_cnt - a0 != 6 || smp_count !== CW'(6) || smp_skew !== EXP_SKEW) begin
            miscompares++;
            $display("FAIL skew_complete: pairs=%0d count=%0d skew=%b required 6 6 %b", acc_cnt - a0, smp_count, smp_skew, EXP_SKEW);
        end
    endtask

    task automatic test_frame_boundary();
        int p0;
        ready_mode = 0; ready_val = 1'b1;
        for (int k = 0; k < 6; k++) begin push_i($urandom); push_q($urandom); end
        upd_fifo();
        p0 = pop_cnt;
        pulse_start(4);
        step();
        vectors++;
        if (smp_skew !== 1'b0 || smp_busy !== 1'b1) begin
            miscompares++; $display("FAIL fb_start: skew=%b busy=%b required 0 1", smp_skew, smp_busy);
        end
        start = 1'b1; num_samples = CW'(9); step(); start = 1'b0;
        step();
        start = 1'b1; step(); start = 1'b0;
        wait_done(40, "fb");
        vectors++;
        if (pop_cnt - p0 != 4 || smp_count !== CW'(4)) begin
            miscompares++; $display("FAIL fb_pops: pops=%0d count=%0d required 4 4", pop_cnt - p0, smp_count);
        end
        vectors++;
        if (ifq.size() != 2 || qfq.size() != 2) begin
            miscompares++; $display("FAIL fb_remaining: i=%0d q=%0d required 2 2", ifq.size(), qfq.size());
        end
        flush_all();
    endtask

    task automatic test_zero_restart();
        int p0;
        ready_mode = 0; ready_val = 1'b1;
        for (int k = 0; k < 3; k++) begin push_i($urandom); push_q($urandom); end
        upd_fifo();
        p0 = pop_cnt;
        pulse_start(0);
        step();
        vectors++;
        if (smp_done !== 1'b1 || smp_busy !== 1'b0 || smp_count !== '0) begin
            miscompares++; $display("FAIL zero_done: done=%b busy=%b count=%0d required 1 0 0", smp_done, smp_busy, smp_count);
        end
        step(); step();
        vectors++;
        if (pop_cnt != p0) begin miscompares++; $display("FAIL zero_pops: got %0d required 0", pop_cnt - p0); end
        pulse_start(3);
        step();
        vectors++;
        if (smp_done !== 1'b0 || smp_busy !== 1'b1) begin
            miscompares++; $display("FAIL restart_clear: done=%b busy=%b required 0 1", smp_done, smp_busy);
        end
        wait_done(40, "restart");
        vectors++;
        if (smp_count !== CW'(3) || pop_cnt - p0 != 3) begin
            miscompares++; $display("FAIL restart_count: count=%0d pops=%0d required 3 3", smp_count, pop_cnt - p0);
        end
    endtask

    task automatic test_random_frames();
        int n, a0, p0;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 12);
            ready_mode = 2;
            pend_i = n; pend_q = n;
            a0 = acc_cnt; p0 = pop_cnt;
            pulse_start(n);
            wait_done(400, "rand");
            vectors++;
            if (acc_cnt - a0 != n || pop_cnt - p0 != n || smp_count !== CW'(n)) begin
                miscompares++;
                $display("FAIL rand_counts: pairs=%0d pops=%0d count=%0d required %0d", acc_cnt - a0, pop_cnt - p0, smp_count, n);
            end
        end
        flush_all();
    endtask

    task automatic test_reset_mid_frame();
        int a0, p0, k;
        ready_mode = 0; ready_val = 1'b1;
        for (int j = 0; j < 8; j++) begin push_i($urandom); push_q($urandom); end
        upd_fifo();
        a0 = acc_cnt;
        pulse_start(8);
        k = 0;
        while (acc_cnt - a0 < 2 && k < 20) begin step(); k++; end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({dm.dm_valid, busy, done, i_rd_en, q_rd_en} !== 5'b0 || dm.dm_i !== '0 || sample_count !== '0) begin
            miscompares++;
            $display("FAIL reset_async: flags=%b i=%h count=%0d required 0 0 0",
                     {dm.dm_valid, busy, done, i_rd_en, q_rd_en}, dm.dm_i, sample_count);
        end
        prev_stall = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        p0 = pop_cnt;
        step(); step(); step();
        vectors++;
        if (smp_busy !== 1'b0 || smp_done !== 1'b0 || pop_cnt != p0 || ifq.size() == 0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b done=%b pops=%0d fifo=%0d required 0 0 0 nonzero",
                     smp_busy, smp_done, pop_cnt - p0, ifq.size());
        end
        flush_all();
    endtask

    initial begin
        test_reset();
        test_full_throughput();
        test_backpressure();
        test_skewed_arrival();
        test_frame_boundary();
        test_zero_restart();
        test_random_frames();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/iq_sample_sequencer.md
Name: iq_sample_sequencer

Overview:
- Controller between the I and Q input FIFOs and the demod datapath.
- Pops I and Q in lockstep and presents paired samples to the demod core over a valid/ready handshake.
- Counts a programmed frame of samples and reports done.
- Flags I/Q stream skew, so one FIFO running ahead of the other is detected instead of silently mispairing samples.

Parameters:
- DATA_WIDTH, 32, width of the I and Q samples.
- COUNT_WIDTH, 20, width of the frame length and sample counter (max frame 2^20-1 samples).
- SKEW_LIMIT, 16, consecutive one-sided-empty cycles that raise skew_err.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle pulse; latches num_samples and begins a frame.
- num_samples  in  COUNT_WIDTH  frame length; 0 means the frame is empty.
- i_empty  in  1  I FIFO empty (FIFO is first-word-fall-through).
- i_dout  in  DATA_WIDTH  I FIFO head word.
- i_rd_en  out  1  I FIFO pop.
- q_empty  in  1  Q FIFO empty (FIFO is first-word-fall-through).
- q_dout  in  DATA_WIDTH  Q FIFO head word.
- q_rd_en  out  1  Q FIFO pop.
- dm_valid  out  1  paired sample valid to the demod.
- dm_i  out  DATA_WIDTH  registered I sample.
- dm_q  out  DATA_WIDTH  registered Q sample.
- dm_ready  in  1  demod accepts when dm_valid && dm_ready.
- busy  out  1  frame in progress.
- done  out  1  frame complete; level output.
- sample_count  out  COUNT_WIDTH  samples accepted by the demod this frame.
- skew_err  out  1  sticky skew flag.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State IDLE; all outputs 0; dm_i and dm_q = 0; internal issued count = 0.
  - Reset asserted mid-frame aborts immediately. FIFO contents are untouched.
- States IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start → latch num_samples into frame_len; clear sample_count and skew_err.
  - Go to RUN, or to DONE if num_samples == 0.
- RUN, pop condition: pop = !i_empty && !q_empty && (issued < frame_len) && (!dm_valid || dm_ready).
- RUN, pop effects:
  - i_rd_en and q_rd_en are asserted together, combinationally, in the same cycle. They are never asserted individually.
  - dm_i/dm_q <= i_dout/q_dout on that edge; dm_valid <= 1; issued++.
  - Pop-to-dm_valid latency is 1 cycle. Full throughput is 1 pair/cycle while dm_ready stays high.
- RUN, no pop: if dm_valid && dm_ready, then dm_valid <= 0.
- RUN, holding: while dm_valid && !dm_ready, dm_i/dm_q/dm_valid hold stable.
- sample_count increments on every dm_valid && dm_ready, in any state.
- RUN → DRAIN when issued reaches frame_len. Pops stop even if the FIFOs are non-empty.
- DRAIN:
  - Waits for the last handshake.
  - On dm_valid && dm_ready: dm_valid <= 0; go to DONE. sample_count == frame_len on entry to DONE.
- DONE: done = 1, busy = 0. Holds until the next start, which behaves exactly as start in IDLE and clears done on the same edge.
- busy = 1 in RUN and DRAIN.
- start received in RUN or DRAIN is ignored. No restart mid-frame.
- Simultaneous events: a pop and acceptance of the previous pair in the same cycle are legal. The new pair replaces the old one with no bubble.
- Counter wrap is impossible because frame_len < 2^COUNT_WIDTH.

Optional Feature:
- Macro: IQ_SKEW_CHECK_EN.
- Defined:
  - In RUN only, a counter increments each cycle where exactly one of i_empty/q_empty is 0.
  - The counter resets to 0 when both are empty or both are non-empty.
  - When the counter reaches SKEW_LIMIT, skew_err <= 1. skew_err is sticky until start or reset.
  - Sequencing is unaffected.
- Undefined: skew_err is tied to 0 and no counter logic is present.

Decomposition:
- Package demod_pkg:
  - seq_state_t enum {IDLE, RUN, DRAIN, DONE}.
  - Default constants for DATA_WIDTH, COUNT_WIDTH, SKEW_LIMIT.
- Sub-module: iq_skew_monitor, containing the one-sided-empty counter and sticky flag. It is instantiated only under IQ_SKEW_CHECK_EN.

Test Plan:
- Full throughput:
  - Stimulus: num_samples=8; both FIFOs pre-loaded with 8 words (I=0x100+k, Q=0x200+k); dm_ready=1.
  - Response: 8 consecutive dm_valid cycles; pairs match in order; done rises 1 cycle after the last handshake; sample_count=8.
- Backpressure:
  - Stimulus: dm_ready toggles 1,0,0,1,…
  - Response: dm_i/dm_q stable while stalled; no pop while dm_valid && !dm_ready; no lost or duplicated pairs.
- Skewed arrival:
  - Stimulus: I FIFO filled, Q empty for 20 cycles.
  - Response: zero pops; skew_err=1 after 16 cycles (macro defined) or stays 0 (undefined). Once Q fills, pairs are correct and in order.
- Frame boundary:
  - Stimulus: num_samples=4 with 6 words queued.
  - Response: exactly 4 pops; 2 words remain; start pulses during RUN are ignored.
- Zero frame and restart:
  - Stimulus: num_samples=0.
  - Response: done on the next cycle with no pops. A following start with 3 samples clears done and completes with sample_count=3.
- Reset mid-frame:
  - Stimulus: reset asserted after 2 of 8 samples.
  - Response: outputs go to 0 asynchronously; state is IDLE after release.
